// File: rtl/debounce2_pkg.sv
// Shared definitions for the two-channel button debouncer (FSM states, default period).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package debounce2_pkg;

    // Per-channel debounce FSM states
    typedef enum logic [1:0] {
        S_LOW    = 2'd0,
        S_WAIT_H = 2'd1,
        S_HIGH   = 2'd2,
        S_WAIT_L = 2'd3
    } state_t;

    // 20 ms at the 12 MHz board oscillator
    localparam int DEBOUNCE_CYCLES_DEF = 240000;

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchronizer, hold counter, 4-state FSM, edge pulses.
// Latency: 2 + DEBOUNCE_CYCLES clk edges from first sample of a clean level change to dout.
// Backpressure: none; free-running, outputs are registered every cycle.
module debounce_ch
    import debounce2_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    state_t           state;

    // Bring the asynchronous pin into the clk domain
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], din};
        end
    end

    // Debounce FSM; the sample that leaves a stable state already counts as the
    // first of the DEBOUNCE_CYCLES agreeing samples, so the wait states start at 1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_LOW;
            cnt   <= '0;
            dout  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                S_LOW: begin
                    dout <= 1'b0;
                    cnt  <= '0;
                    if (sync[1]) begin
                        state <= S_WAIT_H;
                        cnt   <= CNT_W'(1);
                    end
                end
                S_WAIT_H: begin
                    if (!sync[1]) begin
                        state <= S_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_HIGH;
                        cnt   <= '0;
                        dout  <= 1'b1;
                        rise  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    dout <= 1'b1;
                    cnt  <= '0;
                    if (!sync[1]) begin
                        state <= S_WAIT_L;
                        cnt   <= CNT_W'(1);
                    end
                end
                S_WAIT_L: begin
                    if (sync[1]) begin
                        state <= S_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_LOW;
                        cnt   <= '0;
                        dout  <= 1'b0;
                        fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_LOW;
                    cnt   <= '0;
                    dout  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/debounce2.sv
// Two-channel button conditioner feeding gate inputs x0/x1, plus per-channel rise/fall pulses.
// Latency: 2 + DEBOUNCE_CYCLES clk edges; pulses coincide with the x change. Optional macro DEBOUNCE2_TOGGLE_EN.
// Backpressure: none; DEBOUNCE2_TOGGLE_EN makes each debounced rise invert x (falls ignored).
module debounce2
    import debounce2_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] sw,
    output logic       x0,
    output logic       x1,
    output logic [1:0] rise,
    output logic [1:0] fall
);

    logic [1:0] lvl;

    for (genvar i = 0; i < 2; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk  (clk),
            .rstn (rstn),
            .din  (sw[i]),
            .dout (lvl[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

`ifdef DEBOUNCE2_TOGGLE_EN
    logic [1:0] tog;

    // Toggle state absorbs each rise; rise only fires with lvl already 1
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tog <= 2'b00;
        end else begin
            tog <= tog ^ (rise & lvl);
        end
    end

    // Flip in the same cycle as the rise pulse (both operands are flops)
    assign x0 = tog[0] ^ rise[0];
    assign x1 = tog[1] ^ rise[1];
`else
    assign x0 = lvl[0];
    assign x1 = lvl[1];
`endif

endmodule

// File: tb/tb_debounce2.sv
// Self-checking bench for debounce2 with DEBOUNCE_CYCLES=4 against a run-length reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_debounce2;

    localparam int N = 4;

    logic       clk;
    logic       rstn;
    logic [1:0] sw;
    logic       x0, x1;
    logic [1:0] rise, fall;

    int tests;
    int fails;

    // reference model state
    logic [1:0] pipe[$];
    logic [1:0] m_lvl, m_tog, m_rise, m_fall;
    int         m_run[2];

    debounce2 #(.DEBOUNCE_CYCLES(N)) dut (
        .clk  (clk),
        .rstn (rstn),
        .sw   (sw),
        .x0   (x0),
        .x1   (x1),
        .rise (rise),
        .fall (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] exp_x();
`ifdef DEBOUNCE2_TOGGLE_EN
        return m_tog;
`else
        return m_lvl;
`endif
    endfunction

    task automatic model_reset();
        pipe.delete();
        m_lvl  = 2'b00;
        m_tog  = 2'b00;
        m_rise = 2'b00;
        m_fall = 2'b00;
        m_run[0] = 0;
        m_run[1] = 0;
    endtask

    // One clock edge: the model sees the pin value from two edges earlier and
    // flips a channel once N consecutive seen values disagree with its level.
    task automatic tick();
        logic [1:0] seen;
        @(posedge clk);
        m_rise = 2'b00;
        m_fall = 2'b00;
        if (rstn) begin
            pipe.push_back(sw);
            if (pipe.size() > 2) begin
                seen = pipe.pop_front();
                for (int i = 0; i < 2; i++) begin
                    if (seen[i] != m_lvl[i]) begin
                        m_run[i]++;
                        if (m_run[i] == N) begin
                            m_lvl[i] = seen[i];
                            m_run[i] = 0;
                            if (seen[i]) begin
                                m_rise[i] = 1'b1;
                                m_tog[i]  = ~m_tog[i];
                            end else begin
                                m_fall[i] = 1'b1;
                            end
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        sw   = 2'b11;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if ({x1, x0} !== 2'b00 || rise !== 2'b00 || fall !== 2'b00) begin
                fails++;
                $display("FAIL reset_hold: x=%b rise=%b fall=%b, required all 0", {x1, x0}, rise, fall);
            end
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            tests++;
            if ({x1, x0} !== exp_x() || rise !== m_rise || fall !== m_fall) begin
                fails++;
                $display("FAIL reset_release_model edge %0d: x=%b rise=%b fall=%b, required x=%b rise=%b fall=%b",
                         k, {x1, x0}, rise, fall, exp_x(), m_rise, m_fall);
            end
            tests++;
            if (rise !== ((k == 6) ? 2'b11 : 2'b00)) begin
                fails++;
                $display("FAIL reset_release_rise edge %0d: rise=%b, required %b", k, rise, (k == 6) ? 2'b11 : 2'b00);
            end
`ifndef DEBOUNCE2_TOGGLE_EN
            tests++;
            if ({x1, x0} !== ((k >= 6) ? 2'b11 : 2'b00)) begin
                fails++;
                $display("FAIL reset_release_x edge %0d: x=%b, required %b", k, {x1, x0}, (k >= 6) ? 2'b11 : 2'b00);
            end
`endif
        end
    endtask

    // Hold sw steady long enough for the outputs to settle, checking the model throughout
    task automatic settle(input logic [1:0] v, input string name);
        sw = v;
        for (int k = 0; k < 2 * N + 4; k++) begin
            tick();
            tests++;
            if ({x1, x0} !== exp_x() || rise !== m_rise || fall !== m_fall) begin
                fails++;
                $display("FAIL %s_settle: x=%b rise=%b fall=%b, required x=%b rise=%b fall=%b",
                         name, {x1, x0}, rise, fall, exp_x(), m_rise, m_fall);
            end
        end
    endtask

    task automatic test_clean_press();
        logic x1_before;
        settle(2'b00, "press");
        x1_before = x1;
        sw = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            tick();
            tests++;
            if (rise !== ((k == 6) ? 2'b01 : 2'b00) || fall !== 2'b00) begin
                fails++;
                $display("FAIL press_pulse edge %0d: rise=%b fall=%b, required rise=%b fall=00",
                         k, rise, fall, (k == 6) ? 2'b01 : 2'b00);
            end
            tests++;
            if (x1 !== x1_before || {x1, x0} !== exp_x()) begin
                fails++;
                $display("FAIL press_x edge %0d: x=%b, required %b", k, {x1, x0}, exp_x());
            end
        end
    endtask

    task automatic test_bounce();
        logic [11:0] pat;
        int          nrise;
        settle(2'b00, "bounce");
        pat   = 12'b1111_1101_1011;  // applied LSB first: 1,1,0,1,1,0,1,1,1,1,1,1
        nrise = 0;
        for (int k = 0; k < 12 + N + 4; k++) begin
            sw[0] = (k < 12) ? pat[k] : 1'b1;
            tick();
            if (rise[0]) nrise++;
            tests++;
            if ({x1, x0} !== exp_x() || rise !== m_rise || fall !== m_fall) begin
                fails++;
                $display("FAIL bounce_model step %0d: x=%b rise=%b fall=%b, required x=%b rise=%b fall=%b",
                         k, {x1, x0}, rise, fall, exp_x(), m_rise, m_fall);
            end
        end
        tests++;
        if (nrise != 1) begin
            fails++;
            $display("FAIL bounce_rise_count: saw %0d rise pulses, required 1", nrise);
        end
    endtask

    task automatic test_glitch();
        int nfall;
        settle(2'b01, "glitch");
        nfall = 0;
        for (int k = 0; k < 12; k++) begin
            sw[0] = (k < 3) ? 1'b0 : 1'b1;
            tick();
            if (fall[0]) nfall++;
`ifndef DEBOUNCE2_TOGGLE_EN
            tests++;
            if (x0 !== 1'b1) begin
                fails++;
                $display("FAIL glitch_x0 step %0d: x0=%b, required 1", k, x0);
            end
`endif
        end
        tests++;
        if (nfall != 0) begin
            fails++;
            $display("FAIL glitch_fall: saw %0d fall pulses, required 0", nfall);
        end
    endtask

    task automatic test_reset_mid();
        settle(2'b01, "midrst");
        sw[1] = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        tests++;
        if (x1 !== 1'b0 || x0 !== 1'b0 || rise !== 2'b00 || fall !== 2'b00) begin
            fails++;
            $display("FAIL midrst_async: x=%b rise=%b fall=%b, required all 0", {x1, x0}, rise, fall);
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            tests++;
            if (rise[1] !== (k == 6) || {x1, x0} !== exp_x()) begin
                fails++;
                $display("FAIL midrst_release edge %0d: x=%b rise=%b, required x=%b rise1=%b",
                         k, {x1, x0}, rise, exp_x(), (k == 6));
            end
        end
    endtask

    task automatic test_random();
        int hold[2];
        hold[0] = 0;
        hold[1] = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (hold[i] == 0) begin
                    sw[i]   = $urandom_range(0, 1);
                    hold[i] = $urandom_range(1, 2 * N + 2);
                end
                hold[i]--;
            end
            tick();
            tests++;
            if ({x1, x0} !== exp_x() || rise !== m_rise || fall !== m_fall) begin
                fails++;
                $display("FAIL random step %0d: x=%b rise=%b fall=%b, required x=%b rise=%b fall=%b",
                         k, {x1, x0}, rise, fall, exp_x(), m_rise, m_fall);
            end
            tests++;
            if ((rise & fall) !== 2'b00) begin
                fails++;
                $display("FAIL random_excl step %0d: rise=%b fall=%b, required no overlap", k, rise, fall);
            end
        end
    endtask

`ifdef DEBOUNCE2_TOGGLE_EN
    task automatic test_toggle();
        logic [2:0] want;
        int         nrise;
        settle(2'b00, "toggle");
        model_reset();
        rstn = 1'b0;
        #1;
        @(negedge clk);
        rstn  = 1'b1;
        want  = 3'b101;
        nrise = 0;
        for (int p = 0; p < 3; p++) begin
            settle(2'b01, "toggle_press");
            tests++;
            if (x0 !== want[p]) begin
                fails++;
                $display("FAIL toggle_press %0d: x0=%b, required %b", p, x0, want[p]);
            end
            settle(2'b00, "toggle_release");
            tests++;
            if (x0 !== want[p]) begin
                fails++;
                $display("FAIL toggle_release %0d: x0=%b, required %b", p, x0, want[p]);
            end
        end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        rstn  = 1'b0;
        sw    = 2'b00;
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_reset_mid();
        test_random();
`ifdef DEBOUNCE2_TOGGLE_EN
        test_toggle();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
